// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller and its code-checker datapath.
package lock_pkg;

   localparam int unsigned DIGIT_W_DEF = 4;
   localparam int unsigned MAX_LEN_DEF = 4;
   localparam int unsigned LEN_W_DEF   = 3;

   typedef enum logic [1:0] {
      CHK_IDLE = 2'd0,
      CHK_CMP  = 2'd1,
      CHK_DONE = 2'd2
   } chk_state_e;

   // Controller state encodings, shared with the lock controller FSM.
   typedef enum logic [3:0] {
      CTRL_IDLE       = 4'd0,
      CTRL_LOAD_PASS  = 4'd1,
      CTRL_WAIT_PASS  = 4'd2,
      CTRL_LOCKED     = 4'd3,
      CTRL_LOAD_INPUT = 4'd4,
      CTRL_WAIT_INPUT = 4'd5,
      CTRL_COMPARE    = 4'd6,
      CTRL_UNLOCKED   = 4'd7,
      CTRL_ALARM      = 4'd8
   } ctrl_state_e;

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on the rising edge of a level input.
module rise_detect (
   input  logic clk,
   input  logic system_reset,
   input  logic level,
   output logic pulse
);

   logic prev_q;

   always_ff @(posedge clk) begin
      if (system_reset) prev_q <= 1'b0;
      else              prev_q <= level;
   end

   assign pulse = level & ~prev_q;

endmodule

// File: rtl/code_checker.sv
// Password/attempt digit buffers and a digit-serial comparator feeding the lock controller.
module code_checker
   import lock_pkg::*;
#(
   parameter int unsigned DIGIT_W = DIGIT_W_DEF,
   parameter int unsigned MAX_LEN = MAX_LEN_DEF,
   parameter int unsigned LEN_W   = LEN_W_DEF
) (
   input  logic               clk,
   input  logic               system_reset,
   input  logic               resetSignal,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               ld_pass,
   input  logic               ld_input,
   input  logic               compareSignal,
   output logic               doneCompare,
   output logic               match,
   output logic [LEN_W-1:0]   pass_len,
   output logic [LEN_W-1:0]   input_len,
   output logic               busy
);

   localparam int unsigned      IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   chk_state_e         state_q;
   logic [LEN_W-1:0]   idx_q;
   logic [LEN_W-1:0]   pass_len_q;
   logic [LEN_W-1:0]   input_len_q;
   logic               overflow_q;
   logic               sess_q;
   logic               done_q;
   logic               match_q;
   logic               busy_q;
   logic [DIGIT_W-1:0] pass_mem_q [MAX_LEN];
   logic [DIGIT_W-1:0] in_mem_q   [MAX_LEN];

   logic pass_rise, in_rise;
   logic load_ok_c, pass_wr_c, in_wr_c, in_drop_c;
   logic [IDX_W-1:0] pass_idx_c;

   rise_detect u_pass_rise (
      .clk          (clk),
      .system_reset (system_reset),
      .level        (ld_pass),
      .pulse        (pass_rise)
   );

   rise_detect u_in_rise (
      .clk          (clk),
      .system_reset (system_reset),
      .level        (ld_input),
      .pulse        (in_rise)
   );

   // Loads only in IDLE with no soft clear; ld_pass beats a simultaneous ld_input.
   assign load_ok_c  = resetSignal && (state_q == CHK_IDLE);
   assign pass_wr_c  = load_ok_c && pass_rise && (!sess_q || (pass_len_q < MAX_L));
   assign pass_idx_c = sess_q ? IDX_W'(pass_len_q) : '0;
   assign in_wr_c    = load_ok_c && in_rise && !pass_rise && (input_len_q < MAX_L);
   assign in_drop_c  = load_ok_c && in_rise && !pass_rise && (input_len_q >= MAX_L);

   always_ff @(posedge clk) begin
      if (pass_wr_c) pass_mem_q[pass_idx_c]        <= digit_in;
      if (in_wr_c)   in_mem_q[IDX_W'(input_len_q)] <= digit_in;
   end

   always_ff @(posedge clk) begin
      if (system_reset) begin
         state_q     <= CHK_IDLE;
         idx_q       <= '0;
         pass_len_q  <= '0;
         input_len_q <= '0;
         overflow_q  <= 1'b0;
         sess_q      <= 1'b0;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else if (!resetSignal) begin
         state_q     <= CHK_IDLE;
         input_len_q <= '0;
         overflow_q  <= 1'b0;
         sess_q      <= 1'b0;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (pass_wr_c) begin
            pass_len_q <= sess_q ? pass_len_q + LEN_W'(1) : LEN_W'(1);
            sess_q     <= 1'b1;
         end
         if (in_wr_c)   input_len_q <= input_len_q + LEN_W'(1);
         if (in_drop_c) overflow_q  <= 1'b1;

         case (state_q)
            CHK_IDLE: begin
               if (compareSignal) begin
                  state_q <= CHK_CMP;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CHK_CMP: begin
               // Length/empty/overflow screening happens alongside digit 0.
               if ((idx_q == '0) &&
                   ((input_len_q != pass_len_q) || (pass_len_q == '0) || overflow_q)) begin
                  state_q <= CHK_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  match_q <= 1'b0;
               end else if (pass_mem_q[IDX_W'(idx_q)] != in_mem_q[IDX_W'(idx_q)]) begin
                  state_q <= CHK_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  match_q <= 1'b0;
               end else if (idx_q == pass_len_q - LEN_W'(1)) begin
                  state_q <= CHK_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  match_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + LEN_W'(1);
               end
            end
            CHK_DONE: begin
               if (!compareSignal) begin
                  state_q <= CHK_IDLE;
                  done_q  <= 1'b0;
                  match_q <= 1'b0;
               end
            end
            default: begin
               state_q <= CHK_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               match_q <= 1'b0;
            end
         endcase
      end
   end

   assign doneCompare = done_q;
   assign match       = match_q;
   assign pass_len    = pass_len_q;
   assign input_len   = input_len_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_code_checker.sv
// Scoreboard bench for code_checker: driver queues expected compare results, monitor checks them on doneCompare.
module tb_code_checker;

   localparam int unsigned DW = 4;
   localparam int unsigned LW = 3;

   logic          clk = 1'b0;
   logic          system_reset = 1'b1;
   logic          resetSignal = 1'b1;
   logic [DW-1:0] digit_in = '0;
   logic          ld_pass = 1'b0;
   logic          ld_input = 1'b0;
   logic          compareSignal = 1'b0;
   logic          doneCompare, match, busy;
   logic [LW-1:0] pass_len, input_len;

   typedef struct {
      logic m;
      int   edges;
      int   plen;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   t = 0;
   logic cmp_prev = 1'b0;
   logic done_prev = 1'b0;

   code_checker dut (
      .clk           (clk),
      .system_reset  (system_reset),
      .resetSignal   (resetSignal),
      .digit_in      (digit_in),
      .ld_pass       (ld_pass),
      .ld_input      (ld_input),
      .compareSignal (compareSignal),
      .doneCompare   (doneCompare),
      .match         (match),
      .pass_len      (pass_len),
      .input_len     (input_len),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: latency counted in active edges since compareSignal was first seen high.
   always @(negedge clk) begin
      exp_t e;
      if (compareSignal && !cmp_prev) t = -1;
      else                            t++;
      cmp_prev = compareSignal;
      if (doneCompare && !done_prev) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("match", int'(match), int'(e.m));
            chk("latency", t, e.edges);
            chk("pass_len_at_done", int'(pass_len), e.plen);
         end
      end
      done_prev = doneCompare;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_pass(input logic [DW-1:0] d);
      digit_in = d; ld_pass = 1'b1; tick();
      ld_pass = 1'b0; tick();
   endtask

   task automatic press_in(input logic [DW-1:0] d);
      digit_in = d; ld_input = 1'b1; tick();
      ld_input = 1'b0; tick();
   endtask

   task automatic soft_clear();
      resetSignal = 1'b0; tick();
      resetSignal = 1'b1;
   endtask

   task automatic start_cmp(input logic m, input int edges, input int plen);
      exp_t e;
      e.m = m; e.edges = edges; e.plen = plen;
      sb.push_back(e);
      compareSignal = 1'b1;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (doneCompare) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk("done_timeout", 0, 1);
         if (sb.size() != 0) void'(sb.pop_back());
      end
   endtask

   task automatic end_cmp();
      compareSignal = 1'b0; tick();
      chk("done_drop", int'(doneCompare), 0);
      chk("match_drop", int'(match), 0);
   endtask

   task automatic do_cmp(input logic m, input int edges, input int plen);
      start_cmp(m, edges, plen);
      wait_done();
      end_cmp();
   endtask

   initial begin
      tick(); tick();
      chk("rst_done", int'(doneCompare), 0);
      chk("rst_match", int'(match), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pass_len", int'(pass_len), 0);
      chk("rst_input_len", int'(input_len), 0);
      system_reset = 1'b0; tick();

      // 3,7,1 match, then mismatches and short attempt
      press_pass(4'd3); press_pass(4'd7); press_pass(4'd1);
      chk("pass_len_371", int'(pass_len), 3);
      soft_clear();
      press_in(4'd3); press_in(4'd7); press_in(4'd1);
      chk("input_len_371", int'(input_len), 3);
      start_cmp(1'b1, 3, 3);
      tick();
      chk("busy_in_cmp", int'(busy), 1);
      wait_done();
      end_cmp();

      soft_clear();
      press_in(4'd3); press_in(4'd7); press_in(4'd2);
      do_cmp(1'b0, 3, 3);
      soft_clear();
      press_in(4'd9); press_in(4'd7); press_in(4'd1);
      do_cmp(1'b0, 1, 3);
      soft_clear();
      press_in(4'd3); press_in(4'd7);
      do_cmp(1'b0, 1, 3);

      // Empty password after hard reset
      system_reset = 1'b1; tick(); system_reset = 1'b0; tick();
      do_cmp(1'b0, 1, 0);

      // Held ld_pass loads once, then simultaneous rise goes to the password
      digit_in = 4'd5; ld_pass = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      ld_pass = 1'b0; tick();
      chk("hold_pass_len", int'(pass_len), 1);
      digit_in = 4'd6; ld_pass = 1'b1; ld_input = 1'b1; tick();
      ld_pass = 1'b0; ld_input = 1'b0; tick();
      chk("simul_pass_len", int'(pass_len), 2);
      chk("simul_input_len", int'(input_len), 0);
      soft_clear();
      press_in(4'd5); press_in(4'd6);
      do_cmp(1'b1, 2, 2);

      // Full buffers: extra password digit dropped, extra attempt digit overflows
      soft_clear();
      press_pass(4'd1); press_pass(4'd2); press_pass(4'd3); press_pass(4'd4);
      press_pass(4'd9);
      chk("pass_len_full", int'(pass_len), 4);
      soft_clear();
      press_in(4'd1); press_in(4'd2); press_in(4'd3); press_in(4'd4); press_in(4'd5);
      chk("input_len_sat", int'(input_len), 4);
      do_cmp(1'b0, 1, 4);

      // Soft clear during CMP aborts without a done pulse
      soft_clear();
      press_in(4'd1); press_in(4'd2); press_in(4'd3); press_in(4'd4);
      compareSignal = 1'b1; tick(); tick();
      chk("busy_before_abort", int'(busy), 1);
      resetSignal = 1'b0; compareSignal = 1'b0; tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(doneCompare), 0);
      chk("abort_pass_len", int'(pass_len), 4);
      chk("abort_input_len", int'(input_len), 0);
      resetSignal = 1'b1; tick(); tick(); tick();

      // Hard reset while in DONE
      press_in(4'd1); press_in(4'd2); press_in(4'd3); press_in(4'd4);
      start_cmp(1'b1, 4, 4);
      wait_done();
      system_reset = 1'b1; tick();
      chk("hr_done", int'(doneCompare), 0);
      chk("hr_match", int'(match), 0);
      chk("hr_busy", int'(busy), 0);
      chk("hr_pass_len", int'(pass_len), 0);
      chk("hr_input_len", int'(input_len), 0);
      compareSignal = 1'b0; system_reset = 1'b0; tick(); tick();

      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
